mem_req_arbiter: RTL and testbench

Two-to-one request arbiter between the fetch-side and data-side SRAM-like ports of the pipelined CPU and a single shared memory port. It accepts one transaction at a time from either requester using a req/addr_ok/data_ok handshake, holds it stable on the shared port until the memory accepts it, then routes the response back to the owner. Data requests have priority because they come from the older instruction. A starvation guard guarantees forward progress for instruction fetch.

---
 rtl/mem_req_arbiter_pkg.sv | 30 +++
 rtl/mem_req_slot.sv | 21 ++
 rtl/mem_req_arbiter.sv | 145 ++++++++++++++
 tb/tb_mem_req_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_req_arbiter_pkg.sv
// Shared encodings and slot layout for the fetch/data memory arbiter.
// The slot bundle is the request as latched at acceptance time.
package mem_req_arbiter_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2
   } state_t;

   typedef enum logic {
      OWN_INST = 1'b0,
      OWN_DATA = 1'b1
   } owner_t;

   localparam logic [1:0] SIZE_B = 2'd0;
   localparam logic [1:0] SIZE_H = 2'd1;
   localparam logic [1:0] SIZE_W = 2'd2;

   localparam int SLOT_W = 1 + 2 + 4 + 32 + 32;

   typedef struct packed {
      logic        wr;
      logic [1:0]  size;
      logic [3:0]  wstrb;
      logic [31:0] addr;
      logic [31:0] wdata;
   } slot_t;

endpackage

// File: rtl/mem_req_slot.sv
// Load-enabled holding register for one in-flight memory request.
// Synchronous active-low clear.
module mem_req_slot
   import mem_req_arbiter_pkg::*;
(
   input  logic              clk,
   input  logic              resetn,
   input  logic              load,
   input  logic [SLOT_W-1:0] d,
   output logic [SLOT_W-1:0] q
);

   always_ff @(posedge clk) begin
      if (!resetn) begin
         q <= '0;
      end else if (load) begin
         q <= d;
      end
   end

endmodule

// File: rtl/mem_req_arbiter.sv
// Two-to-one fetch/data arbiter onto a single SRAM-like memory port.
// Data has priority; a starvation counter lets fetch win periodically.
module mem_req_arbiter
   import mem_req_arbiter_pkg::*;
#(
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        resetn,

   input  logic        inst_req,
   input  logic        inst_wr,
   input  logic [1:0]  inst_size,
   input  logic [3:0]  inst_wstrb,
   input  logic [31:0] inst_addr,
   input  logic [31:0] inst_wdata,
   output logic        inst_addr_ok,
   output logic        inst_data_ok,
   output logic [31:0] inst_rdata,

   input  logic        data_req,
   input  logic        data_wr,
   input  logic [1:0]  data_size,
   input  logic [3:0]  data_wstrb,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   output logic        data_addr_ok,
   output logic        data_data_ok,
   output logic [31:0] data_rdata,

   output logic        mem_req,
   output logic        mem_wr,
   output logic [1:0]  mem_size,
   output logic [3:0]  mem_wstrb,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_addr_ok,
   input  logic        mem_data_ok,
   input  logic [31:0] mem_rdata
);

   localparam int CW = $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

   state_t        state;
   owner_t        owner;
   logic [CW-1:0] starve_cnt;

   slot_t slot_d;
   slot_t slot_q;

   logic grant_data;
   logic grant_inst;
   logic accept;
   logic resp;
   logic [31:0] resp_data;

   always_comb begin
      grant_data = data_req && !(inst_req && starve_cnt == LIMIT);
      grant_inst = inst_req && !grant_data;
      accept     = resetn && state == S_IDLE
                   && (inst_req || data_req);
      resp       = resetn && state == S_WAIT && mem_data_ok;
      resp_data  = slot_q.wr ? 32'd0 : mem_rdata;

      inst_addr_ok = accept && grant_inst;
      data_addr_ok = accept && grant_data;
      inst_data_ok = resp && owner == OWN_INST;
      data_data_ok = resp && owner == OWN_DATA;
      inst_rdata   = inst_data_ok ? resp_data : 32'd0;
      data_rdata   = data_data_ok ? resp_data : 32'd0;
   end

   always_comb begin
      slot_d = '0;
      if (grant_data) begin
         slot_d.wr    = data_wr;
         slot_d.size  = data_size;
         slot_d.wstrb = data_wstrb;
         slot_d.addr  = data_addr;
         slot_d.wdata = data_wdata;
      end else begin
         slot_d.wr    = inst_wr;
         slot_d.size  = inst_size;
         slot_d.wstrb = inst_wstrb;
         slot_d.addr  = inst_addr;
         slot_d.wdata = inst_wdata;
      end
   end

   mem_req_slot u_slot (
      .clk    (clk),
      .resetn (resetn),
      .load   (accept),
      .d      (slot_d),
      .q      (slot_q)
   );

   assign mem_wr    = slot_q.wr;
   assign mem_size  = slot_q.size;
   assign mem_wstrb = slot_q.wstrb;
   assign mem_addr  = slot_q.addr;
   assign mem_wdata = slot_q.wdata;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state      <= S_IDLE;
         owner      <= OWN_INST;
         starve_cnt <= '0;
         mem_req    <= 1'b0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (accept) begin
                  owner   <= grant_data ? OWN_DATA : OWN_INST;
                  state   <= S_ISSUE;
                  mem_req <= 1'b1;
                  // Only a contested loss counts against fetch
                  if (grant_inst) begin
                     starve_cnt <= '0;
                  end else if (inst_req && starve_cnt != LIMIT) begin
                     starve_cnt <= starve_cnt + 1'b1;
                  end
               end
            end
            S_ISSUE: begin
               if (mem_addr_ok) begin
                  state   <= S_WAIT;
                  mem_req <= 1'b0;
               end
            end
            S_WAIT: begin
               if (mem_data_ok) begin
                  state <= S_IDLE;
               end
            end
            default: begin
               state   <= S_IDLE;
               mem_req <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed and randomized checks for mem_req_arbiter.
// Randomized traffic is compared against a transaction-level model.
module tb_mem_req_arbiter;

   logic        clk = 1'b0;
   logic        resetn;
   logic        inst_req, inst_wr, data_req, data_wr;
   logic [1:0]  inst_size, data_size;
   logic [3:0]  inst_wstrb, data_wstrb;
   logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
   logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
   logic [31:0] inst_rdata, data_rdata;
   logic        mem_req, mem_wr;
   logic [1:0]  mem_size;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_addr, mem_wdata;
   logic        mem_addr_ok, mem_data_ok;
   logic [31:0] mem_rdata;

   int tests = 0;
   int failed = 0;

   always #5 clk = ~clk;

   mem_req_arbiter #(.STARVE_LIMIT(4)) dut (
      .clk(clk), .resetn(resetn),
      .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
      .inst_wstrb(inst_wstrb), .inst_addr(inst_addr),
      .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
      .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
      .data_wstrb(data_wstrb), .data_addr(data_addr),
      .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
      .data_data_ok(data_data_ok), .data_rdata(data_rdata),
      .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size),
      .mem_wstrb(mem_wstrb), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
      .mem_rdata(mem_rdata)
   );

   task automatic tick;
      @(negedge clk);
   endtask

   task automatic idle_inputs;
      inst_req = 0; inst_wr = 0; inst_size = 2; inst_wstrb = 0;
      inst_addr = 0; inst_wdata = 0;
      data_req = 0; data_wr = 0; data_size = 2; data_wstrb = 0;
      data_addr = 0; data_wdata = 0;
      mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
   endtask

   task automatic test_reset;
      idle_inputs();
      resetn = 0;
      inst_req = 1; data_req = 1; mem_addr_ok = 1; mem_data_ok = 1;
      mem_rdata = 32'hffffffff;
      tick();
      #1;
      tests++; if (inst_addr_ok !== 0) begin failed++; $display("FAIL rst_iaok got %b want 0", inst_addr_ok); end
      tests++; if (data_addr_ok !== 0) begin failed++; $display("FAIL rst_daok got %b want 0", data_addr_ok); end
      tests++; if ({inst_data_ok, data_data_ok} !== 2'b00) begin failed++; $display("FAIL rst_dok got %b want 00", {inst_data_ok, data_data_ok}); end
      tests++; if ({inst_rdata, data_rdata} !== 64'd0) begin failed++; $display("FAIL rst_rdata got %h want 0", {inst_rdata, data_rdata}); end
      tests++; if ({mem_req, mem_wr, mem_size, mem_wstrb} !== 8'd0) begin failed++; $display("FAIL rst_memctl got %h want 0", {mem_req, mem_wr, mem_size, mem_wstrb}); end
      tests++; if ({mem_addr, mem_wdata} !== 64'd0) begin failed++; $display("FAIL rst_memdata got %h want 0", {mem_addr, mem_wdata}); end
      idle_inputs();
      resetn = 1;
      tick();
   endtask

   task automatic test_single_inst_read;
      logic seen_d;
      seen_d = 0;
      inst_req = 1; inst_wr = 0; inst_size = 2; inst_addr = 32'h1c000000;
      #1;
      seen_d |= data_data_ok;
      tests++; if (inst_addr_ok !== 1) begin failed++; $display("FAIL single_iaok got %b want 1", inst_addr_ok); end
      tests++; if (data_addr_ok !== 0) begin failed++; $display("FAIL single_daok got %b want 0", data_addr_ok); end
      tick();
      inst_req = 0; inst_addr = 32'h0; mem_addr_ok = 1;
      #1;
      seen_d |= data_data_ok;
      tests++; if (mem_req !== 1) begin failed++; $display("FAIL single_mreq1 got %b want 1", mem_req); end
      tests++; if (mem_addr !== 32'h1c000000) begin failed++; $display("FAIL single_maddr got %h want 1c000000", mem_addr); end
      tick();
      mem_addr_ok = 0;
      #1;
      seen_d |= data_data_ok;
      tests++; if (mem_req !== 0) begin failed++; $display("FAIL single_mreq2 got %b want 0", mem_req); end
      tests++; if (inst_data_ok !== 0) begin failed++; $display("FAIL single_early_dok got %b want 0", inst_data_ok); end
      tick();
      mem_data_ok = 1; mem_rdata = 32'h02800c0c;
      #1;
      seen_d |= data_data_ok;
      tests++; if (inst_data_ok !== 1) begin failed++; $display("FAIL single_idok got %b want 1", inst_data_ok); end
      tests++; if (inst_rdata !== 32'h02800c0c) begin failed++; $display("FAIL single_rdata got %h want 02800c0c", inst_rdata); end
      tick();
      mem_data_ok = 0;
      #1;
      seen_d |= data_data_ok;
      tests++; if (inst_data_ok !== 0) begin failed++; $display("FAIL single_idok_pulse got %b want 0", inst_data_ok); end
      tests++; if (seen_d !== 0) begin failed++; $display("FAIL single_ddok got %b want 0", seen_d); end
      tick();
   endtask

   task automatic test_collision;
      logic [31:0] rd;
      inst_req = 1; inst_wr = 0; inst_addr = 32'h00002000;
      data_req = 1; data_wr = 1; data_addr = 32'h00001000;
      data_wdata = 32'hdeadbeef; data_wstrb = 4'hf; data_size = 2;
      #1;
      tests++; if (data_addr_ok !== 1) begin failed++; $display("FAIL coll_daok got %b want 1", data_addr_ok); end
      tests++; if (inst_addr_ok !== 0) begin failed++; $display("FAIL coll_iaok got %b want 0", inst_addr_ok); end
      tick();
      data_req = 0; data_wdata = 0; mem_addr_ok = 1;
      #1;
      tests++; if ({mem_req, mem_wr} !== 2'b11) begin failed++; $display("FAIL coll_mwr got %b want 11", {mem_req, mem_wr}); end
      tests++; if (mem_wdata !== 32'hdeadbeef) begin failed++; $display("FAIL coll_mwdata got %h want deadbeef", mem_wdata); end
      tests++; if ({mem_addr, mem_wstrb} !== {32'h00001000, 4'hf}) begin failed++; $display("FAIL coll_maddr got %h want 00001000f", {mem_addr, mem_wstrb}); end
      tick();
      mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'h12345678;
      #1;
      tests++; if ({data_data_ok, inst_data_ok, inst_addr_ok} !== 3'b100) begin failed++; $display("FAIL coll_ddok got %b want 100", {data_data_ok, inst_data_ok, inst_addr_ok}); end
      tests++; if (data_rdata !== 32'd0) begin failed++; $display("FAIL coll_wr_rdata got %h want 0", data_rdata); end
      tick();
      mem_data_ok = 0;
      #1;
      tests++; if (inst_addr_ok !== 1) begin failed++; $display("FAIL coll_inst_next got %b want 1", inst_addr_ok); end
      tick();
      inst_req = 0; mem_addr_ok = 1;
      #1;
      tests++; if ({mem_addr, mem_wr} !== {32'h00002000, 1'b0}) begin failed++; $display("FAIL coll_inst_maddr got %h want 000020000", {mem_addr, mem_wr}); end
      tick();
      rd = $urandom;
      mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = rd;
      #1;
      tests++; if ({inst_data_ok, inst_rdata} !== {1'b1, rd}) begin failed++; $display("FAIL coll_inst_resp got %h want %h", {inst_data_ok, inst_rdata}, {1'b1, rd}); end
      tick();
      mem_data_ok = 0;
   endtask

   task automatic test_starvation;
      int starve;
      int inst_wins;
      logic exp_inst;
      starve = 0;
      inst_wins = 0;
      inst_addr = 32'h1c000100;
      for (int r = 0; r < 10; r++) begin
         inst_req = 1; data_req = 1; data_wr = 0; data_addr = 32'h4000 + r;
         #1;
         exp_inst = (starve == 4);
         if (inst_addr_ok === 1) inst_wins++;
         tests++; if ({inst_addr_ok, data_addr_ok} !== {exp_inst, !exp_inst}) begin failed++; $display("FAIL starve_round%0d got %b want %b", r, {inst_addr_ok, data_addr_ok}, {exp_inst, !exp_inst}); end
         if (exp_inst) starve = 0;
         else if (starve < 4) starve++;
         tick();
         data_req = 0; mem_addr_ok = 1;
         tick();
         mem_addr_ok = 0; mem_data_ok = 1;
         tick();
         mem_data_ok = 0;
      end
      inst_req = 0;
      tests++; if (inst_wins !== 2) begin failed++; $display("FAIL starve_inst_wins got %0d want 2", inst_wins); end
   endtask

   task automatic test_backpressure;
      inst_req = 1; inst_wr = 0; inst_addr = 32'h1c000040;
      #1;
      tests++; if (inst_addr_ok !== 1) begin failed++; $display("FAIL bp_iaok got %b want 1", inst_addr_ok); end
      tick();
      for (int i = 0; i < 5; i++) begin
         inst_req = 0; inst_addr = 32'h0; mem_addr_ok = 0;
         #1;
         tests++; if ({mem_req, mem_addr} !== {1'b1, 32'h1c000040}) begin failed++; $display("FAIL bp_hold%0d got %h want 11c000040", i, {mem_req, mem_addr}); end
         tick();
      end
      mem_addr_ok = 1;
      tick();
      mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'hcafe0001;
      #1;
      tests++; if ({inst_data_ok, inst_rdata} !== {1'b1, 32'hcafe0001}) begin failed++; $display("FAIL bp_resp got %h want 1cafe0001", {inst_data_ok, inst_rdata}); end
      tick();
      mem_data_ok = 0;
   endtask

   task automatic test_reset_mid_wait;
      data_req = 1; data_wr = 0; data_addr = 32'h00003000;
      #1;
      tests++; if (data_addr_ok !== 1) begin failed++; $display("FAIL rmw_daok got %b want 1", data_addr_ok); end
      tick();
      data_req = 0; mem_addr_ok = 1;
      tick();
      mem_addr_ok = 0; resetn = 0;
      tick();
      #1;
      tests++; if ({inst_data_ok, data_data_ok, mem_req} !== 3'b000) begin failed++; $display("FAIL rmw_rst_ok got %b want 000", {inst_data_ok, data_data_ok, mem_req}); end
      tests++; if ({mem_addr, mem_wdata, mem_wr, mem_size, mem_wstrb} !== 71'd0) begin failed++; $display("FAIL rmw_rst_mem got %h want 0", {mem_addr, mem_wdata, mem_wr, mem_size, mem_wstrb}); end
      resetn = 1; mem_data_ok = 1; mem_rdata = 32'h55aa55aa;
      #1;
      tests++; if ({inst_data_ok, data_data_ok} !== 2'b00) begin failed++; $display("FAIL rmw_late_dok got %b want 00", {inst_data_ok, data_data_ok}); end
      tick();
      mem_data_ok = 0; inst_req = 1; inst_addr = 32'h1c000080;
      #1;
      tests++; if ({inst_addr_ok, data_data_ok} !== 2'b10) begin failed++; $display("FAIL rmw_idle_after got %b want 10", {inst_addr_ok, data_data_ok}); end
      tick();
      inst_req = 0; mem_addr_ok = 1;
      tick();
      mem_addr_ok = 0; mem_data_ok = 1;
      tick();
      mem_data_ok = 0;
   endtask

   task automatic test_spurious;
      mem_data_ok = 1; mem_rdata = $urandom;
      #1;
      tests++; if ({inst_data_ok, data_data_ok, mem_req} !== 3'b000) begin failed++; $display("FAIL spur_dok got %b want 000", {inst_data_ok, data_data_ok, mem_req}); end
      tick();
      mem_data_ok = 0; data_req = 1; data_addr = 32'h00005000;
      #1;
      tests++; if (data_addr_ok !== 1) begin failed++; $display("FAIL spur_still_idle got %b want 1", data_addr_ok); end
      tick();
      data_req = 0; mem_addr_ok = 1;
      tick();
      mem_addr_ok = 0; mem_data_ok = 1;
      tick();
      mem_data_ok = 0;
   endtask

   task automatic test_random;
      logic ip, dp, busy, issued, own_d, e_iaok, e_daok, e_mreq, e_resp;
      logic [70:0] cur;
      logic [31:0] e_rd;
      int starve;
      idle_inputs();
      resetn = 0;
      tick();
      resetn = 1;
      ip = 0; dp = 0; busy = 0; issued = 0; own_d = 0; cur = '0; starve = 0;
      for (int c = 0; c < 800; c++) begin
         if (!ip && $urandom_range(0, 2) == 0) begin
            ip = 1; inst_wr = 1'($urandom); inst_size = 2'($urandom_range(0, 2));
            inst_wstrb = 4'($urandom); inst_addr = $urandom; inst_wdata = $urandom;
         end
         if (!dp && $urandom_range(0, 2) == 0) begin
            dp = 1; data_wr = 1'($urandom); data_size = 2'($urandom_range(0, 2));
            data_wstrb = 4'($urandom); data_addr = $urandom; data_wdata = $urandom;
         end
         inst_req = ip; data_req = dp;
         mem_addr_ok = 1'($urandom); mem_data_ok = 1'($urandom); mem_rdata = $urandom;
         #1;
         e_daok = !busy && dp && !(ip && starve == 4);
         e_iaok = !busy && ip && !e_daok;
         e_mreq = busy && !issued;
         e_resp = busy && issued && mem_data_ok;
         tests++; if ({inst_addr_ok, data_addr_ok} !== {e_iaok, e_daok}) begin failed++; $display("FAIL rnd_aok c%0d got %b want %b", c, {inst_addr_ok, data_addr_ok}, {e_iaok, e_daok}); end
         tests++; if ({inst_data_ok, data_data_ok} !== {e_resp && !own_d, e_resp && own_d}) begin failed++; $display("FAIL rnd_dok c%0d got %b want %b", c, {inst_data_ok, data_data_ok}, {e_resp && !own_d, e_resp && own_d}); end
         tests++; if (mem_req !== e_mreq) begin failed++; $display("FAIL rnd_mreq c%0d got %b want %b", c, mem_req, e_mreq); end
         if (e_mreq) begin
            tests++; if ({mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata} !== cur) begin failed++; $display("FAIL rnd_mfields c%0d got %h want %h", c, {mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata}, cur); end
         end
         if (e_resp) begin
            e_rd = cur[70] ? 32'd0 : mem_rdata;
            tests++; if ((own_d ? data_rdata : inst_rdata) !== e_rd) begin failed++; $display("FAIL rnd_rdata c%0d got %h want %h", c, own_d ? data_rdata : inst_rdata, e_rd); end
         end
         if (e_iaok || e_daok) begin
            busy = 1; issued = 0; own_d = e_daok;
            if (e_daok) begin
               cur = {data_wr, data_size, data_wstrb, data_addr, data_wdata};
               if (ip && starve < 4) starve++;
               dp = 0;
            end else begin
               cur = {inst_wr, inst_size, inst_wstrb, inst_addr, inst_wdata};
               starve = 0;
               ip = 0;
            end
         end else if (e_mreq && mem_addr_ok) begin
            issued = 1;
         end else if (e_resp) begin
            busy = 0;
         end
         tick();
         if (!dp) begin data_addr = $urandom; data_wdata = $urandom; end
         if (!ip) begin inst_addr = $urandom; inst_wdata = $urandom; end
      end
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      resetn = 0;
      test_reset();
      test_single_inst_read();
      test_collision();
      test_starvation();
      test_backpressure();
      test_reset_mid_wait();
      test_spurious();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
